// File: rtl/adc_frontend_pkg.sv
// Shared types and default constants for the ADC acquisition front-end.
package adc_frontend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } fe_state_e;

  localparam int unsigned DEF_DATA_WIDTH   = 12;
  localparam int unsigned DEF_ADC_DIV      = 20;
  localparam int unsigned DEF_SYNC_STAGES  = 2;
  localparam int unsigned DEF_DEBOUNCE     = 4;
  localparam int unsigned DEF_PERIOD_WIDTH = 24;
  localparam int unsigned DEF_TOL          = 2;
  localparam int unsigned DEF_STABLE_COUNT = 4;

endpackage

// File: rtl/adc_frontend_sync_debounce.sv
// Multi-flop synchroniser followed by a debouncer; the output only changes
// after the synchronised input has disagreed with it for DEBOUNCE cycles.
module sync_debounce
  import adc_frontend_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE    = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (synced != level_q) begin
      if (cnt_q == CW'(DEBOUNCE - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/adc_frontend.sv
// Acquisition front-end: ADC clock divider and word capture, comparator
// conditioning, period measurement and lock detection feeding dual_buffer.
module adc_frontend
  import adc_frontend_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned ADC_DIV      = DEF_ADC_DIV,
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE     = DEF_DEBOUNCE,
  parameter int unsigned PERIOD_WIDTH = DEF_PERIOD_WIDTH,
  parameter int unsigned TOL          = DEF_TOL,
  parameter int unsigned STABLE_COUNT = DEF_STABLE_COUNT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   adc_data,
  input  logic                    signal_in,
  output logic                    adc_clk,
  output logic [DATA_WIDTH-1:0]   sync_adc_data,
  output logic                    sample_valid,
  output logic                    sync_signal_in,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid,
  output logic                    stable
);

  localparam int unsigned DCW = $clog2(ADC_DIV);
  localparam int unsigned MCW = $clog2(STABLE_COUNT + 1);
  localparam int unsigned XW  = PERIOD_WIDTH + 1;

  logic [DCW-1:0]          div_cnt_q, div_cnt_d;
  logic                    adc_clk_q, adc_clk_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    sv_q, sv_d;

  logic                    sig_level, sig_prev_q;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [PERIOD_WIDTH-1:0] prev_q, prev_d;
  logic                    pv_q, pv_d;
  logic                    cmp_q, cmp_d;
  logic [MCW-1:0]          mc_q, mc_d, mc_inc;
  fe_state_e               state_q, state_d;

  logic                    rise, sat, match;
  logic [PERIOD_WIDTH-1:0] measured;
  logic signed [XW-1:0]    diff;
  logic [XW-1:0]           abs_diff;

  sync_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE   (DEBOUNCE)
  ) u_sig_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(signal_in),
    .level_o(sig_level)
  );

  // Divider and capture: the word is taken on the edge that drops adc_clk.
  always_comb begin
    div_cnt_d = (div_cnt_q == DCW'(ADC_DIV - 1)) ? '0 : div_cnt_q + 1'b1;
    adc_clk_d = adc_clk_q;
    if (div_cnt_q == DCW'(ADC_DIV - 1) || div_cnt_q == DCW'(ADC_DIV / 2 - 1)) begin
      adc_clk_d = ~adc_clk_q;
    end
    sv_d   = adc_clk_q & ~adc_clk_d;
    data_d = sv_d ? adc_data : data_q;
  end

  assign rise     = sig_level & ~sig_prev_q;
  assign sat      = &cnt_q;
  assign measured = cnt_q + 1'b1;
  assign mc_inc   = mc_q + 1'b1;
  assign diff     = $signed({1'b0, period_q}) - $signed({1'b0, prev_q});
  assign abs_diff = diff[XW-1] ? $unsigned(-diff) : $unsigned(diff);
  assign match    = (abs_diff <= XW'(TOL));

  // cmp_q marks a period_valid whose edge arrived in TRACK/LOCKED; the pulse
  // produced by the FIRST edge only seeds prev_period and is not compared.
  always_comb begin
    cnt_d    = rise ? '0 : (sat ? cnt_q : cnt_q + 1'b1);
    period_d = period_q;
    pv_d     = 1'b0;
    cmp_d    = 1'b0;
    prev_d   = prev_q;
    mc_d     = mc_q;
    state_d  = state_q;

    if (rise && !sat && state_q != ST_IDLE) begin
      pv_d     = 1'b1;
      period_d = measured;
      cmp_d    = (state_q == ST_TRACK) || (state_q == ST_LOCKED);
    end

    if (sat && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      mc_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rise) state_d = ST_FIRST;
        end
        ST_FIRST: begin
          if (rise) begin
            prev_d  = measured;
            state_d = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (cmp_q) begin
            prev_d = period_q;
            if (match) begin
              mc_d = mc_inc;
              if (mc_inc >= MCW'(STABLE_COUNT)) state_d = ST_LOCKED;
            end else begin
              mc_d = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (cmp_q) begin
            prev_d = period_q;
            if (match) begin
              mc_d = (mc_q >= MCW'(STABLE_COUNT)) ? mc_q : mc_inc;
            end else begin
              mc_d    = '0;
              state_d = ST_TRACK;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      adc_clk_q  <= 1'b0;
      data_q     <= '0;
      sv_q       <= 1'b0;
      sig_prev_q <= 1'b0;
      cnt_q      <= '0;
      period_q   <= '0;
      pv_q       <= 1'b0;
      cmp_q      <= 1'b0;
      prev_q     <= '0;
      mc_q       <= '0;
      state_q    <= ST_IDLE;
    end else begin
      div_cnt_q  <= div_cnt_d;
      adc_clk_q  <= adc_clk_d;
      data_q     <= data_d;
      sv_q       <= sv_d;
      sig_prev_q <= sig_level;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      pv_q       <= pv_d;
      cmp_q      <= cmp_d;
      prev_q     <= prev_d;
      mc_q       <= mc_d;
      state_q    <= state_d;
    end
  end

  assign adc_clk        = adc_clk_q;
  assign sync_adc_data  = data_q;
  assign sample_valid   = sv_q;
  assign sync_signal_in = sig_level;
  assign period         = period_q;
  assign period_valid   = pv_q;
  assign stable         = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_adc_frontend.sv
// Directed bench for adc_frontend: divider/capture table, glitch rejection,
// lock, tolerance, timeout and reset sequences.
module tb_adc_frontend;

  localparam int unsigned DW = 12;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] adc_data;
  logic          signal_in;
  logic          adc_clk;
  logic [DW-1:0] sync_adc_data;
  logic          sample_valid;
  logic          sync_signal_in;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          stable;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   pv_val[$];
  int   pv_cyc[$];
  int   st_val[$];
  int   st_cyc[$];
  logic st_last = 1'b0;

  typedef struct {
    int            edge_n;
    logic          exp_clk;
    logic          exp_sv;
    logic [DW-1:0] exp_data;
  } cap_vec_t;

  adc_frontend #(
    .DATA_WIDTH  (DW),
    .ADC_DIV     (20),
    .SYNC_STAGES (2),
    .DEBOUNCE    (4),
    .PERIOD_WIDTH(PW),
    .TOL         (2),
    .STABLE_COUNT(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .adc_data      (adc_data),
    .signal_in     (signal_in),
    .adc_clk       (adc_clk),
    .sync_adc_data (sync_adc_data),
    .sample_valid  (sample_valid),
    .sync_signal_in(sync_signal_in),
    .period        (period),
    .period_valid  (period_valid),
    .stable        (stable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (period_valid === 1'b1) begin
      pv_val.push_back(int'(period));
      pv_cyc.push_back(cyc);
    end
    if (stable !== st_last) begin
      st_val.push_back(int'(stable));
      st_cyc.push_back(cyc);
      st_last = stable;
    end
  endtask

  task automatic check_zero(input string tag);
    chk($sformatf("%s.adc_clk", tag), adc_clk, 0);
    chk($sformatf("%s.sync_adc_data", tag), sync_adc_data, 0);
    chk($sformatf("%s.sample_valid", tag), sample_valid, 0);
    chk($sformatf("%s.sync_signal_in", tag), sync_signal_in, 0);
    chk($sformatf("%s.period", tag), period, 0);
    chk($sformatf("%s.period_valid", tag), period_valid, 0);
    chk($sformatf("%s.stable", tag), stable, 0);
  endtask

  task automatic drive_period(input int p);
    signal_in = 1'b1;
    repeat (p / 2) tick();
    signal_in = 1'b0;
    repeat (p - p / 2) tick();
  endtask

  task automatic clear_logs();
    pv_val.delete();
    pv_cyc.delete();
    st_val.delete();
    st_cyc.delete();
    st_last = stable;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cap_vec_t cap[14];
    int       ci, sv_cnt, hi_cnt, rise_idx;
    logic     prev_clk, seen;
    int       per[15];
    int       exp_pv[14];

    cap[0]  = '{9,  1'b0, 1'b0, 12'd0};
    cap[1]  = '{10, 1'b1, 1'b0, 12'd0};
    cap[2]  = '{11, 1'b1, 1'b0, 12'd0};
    cap[3]  = '{19, 1'b1, 1'b0, 12'd0};
    cap[4]  = '{20, 1'b0, 1'b1, 12'd0};
    cap[5]  = '{21, 1'b0, 1'b0, 12'd0};
    cap[6]  = '{30, 1'b1, 1'b0, 12'd0};
    cap[7]  = '{39, 1'b1, 1'b0, 12'd0};
    cap[8]  = '{40, 1'b0, 1'b1, 12'd1};
    cap[9]  = '{41, 1'b0, 1'b0, 12'd1};
    cap[10] = '{50, 1'b1, 1'b0, 12'd1};
    cap[11] = '{60, 1'b0, 1'b1, 12'd2};
    cap[12] = '{61, 1'b0, 1'b0, 12'd2};
    cap[13] = '{80, 1'b0, 1'b1, 12'd3};

    per    = '{100, 100, 100, 100, 100, 100, 101, 99, 110, 100, 100, 100, 100, 100, 100};
    exp_pv = '{100, 100, 100, 100, 100, 100, 101, 99, 110, 100, 100, 100, 100, 100};

    // Reset state
    rst       = 1'b1;
    adc_data  = '0;
    signal_in = 1'b0;
    repeat (5) tick();
    check_zero("reset");
    rst = 1'b0;

    // Divider and capture with a ramp advanced at each adc_clk rise
    ci       = 0;
    sv_cnt   = 0;
    hi_cnt   = 0;
    rise_idx = 0;
    prev_clk = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (sample_valid === 1'b1) sv_cnt++;
      if (adc_clk === 1'b1) hi_cnt++;
      if (adc_clk === 1'b1 && prev_clk == 1'b0) begin
        adc_data = DW'(rise_idx);
        rise_idx++;
      end
      prev_clk = adc_clk;
      if (ci < 14 && cap[ci].edge_n == k) begin
        chk($sformatf("adc_clk@%0d", k), adc_clk, cap[ci].exp_clk);
        chk($sformatf("sample_valid@%0d", k), sample_valid, cap[ci].exp_sv);
        chk($sformatf("sync_adc_data@%0d", k), sync_adc_data, cap[ci].exp_data);
        ci++;
      end
    end
    chk("cap_table_done", ci, 14);
    chk("sample_valid_pulses", sv_cnt, 4);
    chk("adc_clk_high_cycles", hi_cnt, 40);

    // 3-cycle glitch must not reach the output
    signal_in = 1'b1;
    repeat (3) tick();
    signal_in = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (sync_signal_in !== 1'b0) seen = 1'b1;
    end
    chk("glitch_reject", seen, 0);

    // 10-cycle pulse: output follows 6 cycles after each input edge
    clear_logs();
    signal_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 10) signal_in = 1'b0;
      if (i == 5)  chk("pulse_rise_pre", sync_signal_in, 0);
      if (i == 6)  chk("pulse_rise", sync_signal_in, 1);
      if (i == 15) chk("pulse_fall_pre", sync_signal_in, 1);
      if (i == 16) chk("pulse_fall", sync_signal_in, 0);
    end
    chk("idle_first_edge_no_pv", pv_val.size(), 0);

    rst = 1'b1;
    tick();
    check_zero("rst_pulse");
    rst = 1'b0;

    // Lock, tolerance, relock, then timeout with signal held low
    clear_logs();
    foreach (per[i]) drive_period(per[i]);
    repeat (300) tick();
    chk("lock_pv_count", pv_val.size(), 14);
    for (int i = 0; i < 14 && i < pv_val.size(); i++)
      chk($sformatf("lock_period[%0d]", i), pv_val[i], exp_pv[i]);
    chk("lock_stable_transitions", st_val.size(), 4);
    if (st_val.size() >= 4 && pv_cyc.size() >= 14) begin
      chk("lock_rise_val", st_val[0], 1);
      chk("lock_rise_cyc", st_cyc[0], pv_cyc[4] + 1);
      chk("mismatch_drop_val", st_val[1], 0);
      chk("mismatch_drop_cyc", st_cyc[1], pv_cyc[8] + 1);
      chk("relock_val", st_val[2], 1);
      chk("relock_cyc", st_cyc[2], pv_cyc[13] + 1);
      chk("timeout_drop_val", st_val[3], 0);
      chk("timeout_drop_cyc", st_cyc[3], pv_cyc[13] + 256);
    end

    // After timeout the first edge is a fresh first edge
    clear_logs();
    repeat (7) drive_period(100);
    chk("resume_pv_count", pv_val.size(), 6);
    for (int i = 0; i < 6 && i < pv_val.size(); i++)
      chk($sformatf("resume_period[%0d]", i), pv_val[i], 100);
    chk("resume_stable_transitions", st_val.size(), 1);
    if (st_val.size() >= 1 && pv_cyc.size() >= 5) begin
      chk("resume_lock_val", st_val[0], 1);
      chk("resume_lock_cyc", st_cyc[0], pv_cyc[4] + 1);
    end
    chk("mid_lock_stable", stable, 1);

    rst = 1'b1;
    tick();
    check_zero("mid_lock_rst");
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_frontend.md
# adc_frontend

Single-clock acquisition front-end that feeds `dual_buffer`. It generates the divided ADC sample clock and captures parallel ADC words into the system domain. It synchronises and debounces the comparator square wave and measures its period. It asserts `stable` once the period has repeated within tolerance. Its outputs drive `adc_clk`, `sync_adc_data`, `sync_signal_in` and `stable` of the capture buffer directly.

## Interface
- `DATA_WIDTH`, 12: ADC word width.
- `ADC_DIV`, 20: clk cycles per `adc_clk` period. Even, ≥4.
- `SYNC_STAGES`, 2: synchroniser flops on `signal_in`. ≥2.
- `DEBOUNCE`, 4: consecutive agreeing cycles required before `sync_signal_in` changes. ≥1.
- `PERIOD_WIDTH`, 24: width of the period counter.
- `TOL`, 2: allowed |Δperiod| in clk cycles for a match.
- `STABLE_COUNT`, 4: consecutive matches required to assert `stable`.
- `clk`  in  1  system clock. All logic runs on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `adc_data`  in  DATA_WIDTH  ADC parallel output. Valid around the falling edge of `adc_clk`.
- `signal_in`  in  1  asynchronous comparator output.
- `adc_clk`  out  1  divided sample clock to the ADC and `dual_buffer`.
- `sync_adc_data`  out  DATA_WIDTH  captured ADC word.
- `sample_valid`  out  1  one-cycle pulse when `sync_adc_data` updates.
- `sync_signal_in`  out  1  synchronised, debounced comparator level.
- `period`  out  PERIOD_WIDTH  last measured rising-to-rising period, in clk cycles.
- `period_valid`  out  1  one-cycle pulse when `period` updates.
- `stable`  out  1  period locked.

## Operation
- **Reset values.** All outputs are 0. The divider count, synchroniser, debounce count, period counter, match count and FSM (IDLE) are also cleared.
- **Divider.**
  - `div_cnt` runs 0..ADC_DIV-1 and wraps.
  - `adc_clk` toggles on the edge where `div_cnt` equals ADC_DIV/2-1 or ADC_DIV-1.
  - With the defaults, the first rise of `adc_clk` is at clk edge 10 after reset release, and the first fall is at edge 20.
- **Capture.**
  - On the clk edge that drives `adc_clk` 1→0, load `sync_adc_data` with `adc_data` and pulse `sample_valid`.
  - There is no capture on the rise.
- **Sync and debounce.**
  - `signal_in` passes through SYNC_STAGES flops.
  - The debounce counter increments while the synchronised value differs from `sync_signal_in`, and clears whenever they agree.
  - When the counter reaches DEBOUNCE, `sync_signal_in` flips and the counter clears.
  - Glitches shorter than DEBOUNCE cycles never reach the output.
- **Period counter.**
  - Increments every cycle and saturates at all-ones.
  - A rising edge of `sync_signal_in` is detected against a registered copy.
  - On an edge with the counter not saturated and the FSM not in IDLE: `period` ← counter+1, and `period_valid` pulses one cycle after the edge.
  - The counter restarts at 0 on every edge.
- **FSM (state enum in the package).**
  - IDLE: on the first edge → FIRST. No `period_valid` is produced.
  - FIRST: on the next edge, record `period` into `prev_period` → TRACK.
  - TRACK: on each `period_valid`, compute match = |period − prev_period| ≤ TOL.
    - On a match, `match_cnt`++.
    - On a mismatch, `match_cnt` ← 0.
    - In both cases `prev_period` ← `period`.
    - When `match_cnt` reaches STABLE_COUNT → LOCKED.
  - LOCKED: `stable` = 1. A mismatch clears `match_cnt` and `stable` and returns to TRACK.
- **Timeout.** If the period counter saturates in any state other than IDLE, `stable` ← 0, `match_cnt` ← 0 and the FSM goes to IDLE. The next edge is treated as a first edge.
- **Width rule.** The difference is computed at PERIOD_WIDTH+1 bits signed, and its absolute value is compared against TOL. There is no wrap-around.

## Timing
- **Capture latency.** `adc_data` is sampled on the `adc_clk` falling edge. `sync_adc_data` and `sample_valid` are valid the same cycle, registered.
- **`signal_in` to `sync_signal_in`.** SYNC_STAGES + DEBOUNCE cycles: 6 with the defaults.
- **Edge to `period_valid`.** One cycle after the `sync_signal_in` rise.
- **`stable` assertion.** `stable` rises one cycle after the `period_valid` that carries the STABLE_COUNT-th consecutive match. With the defaults that is the 6th rising edge.
- **Drop of lock.** `stable` falls one cycle after a mismatching `period_valid`, or on the cycle after saturation.
- **Simultaneous edge and saturation.** Saturation wins: no `period_valid` is produced, and the FSM goes to IDLE.
- **Reset mid-operation.** Every register returns to its reset value on the next clk edge. `adc_clk` is forced low.

## Structure
- `adc_frontend_pkg`: FSM state enum (IDLE, FIRST, TRACK, LOCKED) and default parameter constants.
- Sub-module `sync_debounce` (parameters SYNC_STAGES, DEBOUNCE): synchroniser plus debounce. It is reusable for other async inputs.
- The divider, capture, period counter and FSM live in `adc_frontend`.

## Test plan
- **Reset values.** Hold `rst` for 5 cycles → all outputs 0. After release, `adc_clk` rises at edge 10 and falls at edge 20, with period 20 and duty 50%.
- **Capture.** Ramp `adc_data` by +1 at each `adc_clk` rise, starting at 0 → `sync_adc_data` equals 0,1,2,… each with a one-cycle `sample_valid` at the fall.
- **Glitch rejection.** A 3-cycle high glitch on `signal_in` → `sync_signal_in` stays 0. A 10-cycle high pulse → `sync_signal_in` rises 6 cycles after the input rise.
- **Lock.** Square wave with period 100 on `signal_in` → `period` = 100 on each pulse. `stable` = 1 one cycle after the 6th rising edge's `period_valid`.
- **Tolerance.** While locked, periods of 101 then 99 → `stable` holds. A period of 110 → `stable` = 0, and it re-locks after 4 further matches.
- **Timeout and reset.** Stop toggling while locked → at saturation `stable` = 0 and the FSM is in IDLE. Pulse `rst` mid-lock → all outputs 0 next cycle.
